// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the sequential wide adder.
// FSM state encoding and default chunk geometry.
package wide_add_seq_pkg;

    localparam int N_DEF      = 8;
    localparam int CHUNKS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_seq_csa_slice.sv
// N-bit carry-select adder slice used once per RUN cycle.
// Both carry-in outcomes are precomputed and the real carry picks one.
module csa_slice
    import wide_add_seq_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] w_s0;
    logic [N:0] w_s1;

    assign w_s0 = {1'b0, x} + {1'b0, y};
    assign w_s1 = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, 1'b1};

    assign {cout, s} = cin ? w_s1 : w_s0;

endmodule

// File: rtl/wide_add_seq.sv
// Sequential W = N*CHUNKS bit adder, one N-bit chunk per cycle.
// Define WIDE_ADD_SEQ_SUB_EN to enable subtraction (a + ~b + 1) via sub.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int CHUNKS = CHUNKS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*CHUNKS-1:0] a,
    input  logic [N*CHUNKS-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                busy,
    output logic                done,
    output logic [N*CHUNKS-1:0] sum,
    output logic                cout
);

    localparam int W  = N * CHUNKS;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_work;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_cout;
    logic            r_busy;
    logic            r_done;
    logic [CW-1:0]   r_cnt;

    logic [W-1:0]    w_b_in;
    logic            w_c_in;
    logic [N-1:0]    w_s;
    logic            w_co;
    logic [W-1:0]    w_work_next;

`ifdef WIDE_ADD_SEQ_SUB_EN
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_b_in = b;
    assign w_c_in = cin;
`endif

    csa_slice #(.N(N)) u_slice (
        .x    (r_a[N-1:0]),
        .y    (r_b[N-1:0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co)
    );

    // Working register with the current chunk result merged in.
    always_comb begin
        w_work_next = r_work;
        w_work_next[int'(r_cnt) * N +: N] = w_s;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_c_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_co;
                    r_a     <= r_a >> N;
                    r_b     <= r_b >> N;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_work_next;
                        r_cout  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (N=8, CHUNKS=4).
// Honours WIDE_ADD_SEQ_SUB_EN in its reference model.
module tb_wide_add_seq;

    localparam int N      = 8;
    localparam int CHUNKS = 4;
    localparam int W      = N * CHUNKS;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[$];

    wide_add_seq #(.N(N), .CHUNKS(CHUNKS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference: plain W+1 bit arithmetic on the accepted operands.
    function automatic logic [W:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c, input logic s);
        logic [W:0] r;
`ifdef WIDE_ADD_SEQ_SUB_EN
        if (s)
            r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else
            r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
`else
        r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        if (s) r = r;
`endif
        return r;
    endfunction

    // Start in cycle 0, check busy/done every cycle through cycle CHUNKS+1.
    task automatic run_op(input string name, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic vc,
                          input logic vs, input logic [W-1:0] es,
                          input logic ec);
        @(negedge clk);
        start = 1'b1; a = va; b = vb; cin = vc; sub = vs;
        for (int k = 1; k <= CHUNKS + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            if (k == 1 || k == CHUNKS + 1) begin
                chk({name, "_busy"}, 64'(busy), 64'(k <= CHUNKS));
                chk({name, "_done"}, 64'(done), 64'(k == CHUNKS + 1));
            end else if (busy !== 1'b1 || done !== 1'b0) begin
                chk({name, "_mid"}, {62'd0, busy, done}, 64'b10);
            end
        end
        chk({name, "_sum"}, 64'(sum), 64'(es));
        chk({name, "_cout"}, 64'(cout), 64'(ec));
    endtask

    logic [W:0]   e1;
    logic [W:0]   e2;
    logic [W:0]   er;
    logic [W-1:0] ta;
    logic [W-1:0] tb2;
    logic         tc;
    logic         ts;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        rst = 1'b0;

        vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0,
                         32'h00000100, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0,
                         32'h00000000, 1'b1});
        vecs.push_back('{32'h00000000, 32'h00000000, 1'b0, 1'b0,
                         32'h00000000, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0,
                         32'hFFFFFFFF, 1'b1});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0,
                         32'h00000000, 1'b1});
        vecs.push_back('{32'h12345678, 32'h87654321, 1'b0, 1'b0,
                         32'h99999999, 1'b0});
        vecs.push_back('{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0,
                         32'h01000100, 1'b0});
`ifdef WIDE_ADD_SEQ_SUB_EN
        vecs.push_back('{32'h00000010, 32'h00000020, 1'b0, 1'b1,
                         32'hFFFFFFF0, 1'b0});
        vecs.push_back('{32'h00000005, 32'h00000003, 1'b0, 1'b1,
                         32'h00000002, 1'b1});
`else
        vecs.push_back('{32'h00000010, 32'h00000020, 1'b0, 1'b1,
                         32'h00000030, 1'b0});
        vecs.push_back('{32'h00000005, 32'h00000003, 1'b0, 1'b1,
                         32'h00000008, 1'b0});
`endif

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].cin, vecs[i].sub, vecs[i].exp_sum,
                   vecs[i].exp_cout);

        for (int i = 0; i < 20; i++) begin
            ta = W'($urandom); tb2 = W'($urandom);
            if (i % 4 == 0) tb2 = ~ta;
            tc = 1'($urandom); ts = 1'($urandom);
            er = model(ta, tb2, tc, ts);
            run_op($sformatf("rnd%0d", i), ta, tb2, tc, ts,
                   er[W-1:0], er[W]);
        end

        // start held high cycles 0..6 with operands changing every cycle.
        @(negedge clk);
        ta = W'($urandom); tb2 = W'($urandom);
        tc = 1'($urandom); ts = 1'($urandom);
        start = 1'b1; a = ta; b = tb2; cin = tc; sub = ts;
        e1 = model(ta, tb2, tc, ts);
        e2 = '0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 4)
                chk($sformatf("hold_busy%0d", k), 64'(busy), 64'd1);
            if (k == 5) begin
                chk("hold_done5", 64'(done), 64'd1);
                chk("hold_busy5", 64'(busy), 64'd0);
            end
            if (k == 6) chk("hold_done6", 64'(done), 64'd0);
            if (k >= 7 && k <= 10)
                chk($sformatf("hold_busy%0d", k), 64'(busy), 64'd1);
            if (k >= 5 && k <= 10)
                chk($sformatf("hold_sum%0d", k), 64'(sum), 64'(e1[W-1:0]));
            if (k == 11) begin
                chk("hold2_done", 64'(done), 64'd1);
                chk("hold2_sum", 64'(sum), 64'(e2[W-1:0]));
                chk("hold2_cout", 64'(cout), 64'(e2[W]));
            end
            if (k <= 6) begin
                ta = W'($urandom); tb2 = W'($urandom);
                tc = 1'($urandom); ts = 1'($urandom);
                a = ta; b = tb2; cin = tc; sub = ts;
                if (k == 6) e2 = model(ta, tb2, tc, ts);
            end else begin
                start = 1'b0;
            end
        end

        // Make sure sum is nonzero so the reset clear is observable.
        run_op("pre_rst", 32'h11111111, 32'h22222222, 1'b0, 1'b0,
               32'h33333333, 1'b0);

        // Reset in cycle 3 of a run abandons it.
        @(negedge clk);
        start = 1'b1; a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                rst = 1'b0;
                chk("rstrun_busy", 64'(busy), 64'd0);
                chk("rstrun_sum",  64'(sum),  64'd0);
                chk("rstrun_cout", 64'(cout), 64'd0);
            end
            if (k >= 4 && done !== 1'b0)
                chk($sformatf("rstrun_done%0d", k), 64'(done), 64'd0);
        end
        chk("rstrun_idle", 64'(busy), 64'd0);

        run_op("post_rst", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0,
               32'h00010000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter N, default 8: width in bits of one adder chunk.
REQ-002 SHALL have parameter CHUNKS, default 4: number of chunks per operand; operand width W = N*CHUNKS.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin one wide add; accepted only in IDLE.
REQ-006 SHALL have port a  input  W  first operand; sampled when start is accepted.
REQ-007 SHALL have port b  input  W  second operand; sampled when start is accepted.
REQ-008 SHALL have port cin  input  1  carry-in to chunk 0; sampled when start is accepted.
REQ-009 SHALL have port sub  input  1  subtract request; sampled when start is accepted; ignored without the macro (REQ-025).
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse when sum/cout become valid.
REQ-012 SHALL have port sum  output  W  registered result.
REQ-013 SHALL have port cout  output  1  registered carry out of the top chunk.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; IDLE --start--> RUN; RUN --last chunk--> DONE; DONE --> IDLE unconditionally.
REQ-015 On accepted start SHALL latch a, b and the carry (cin, or 1 when subtracting), and clear the chunk counter to 0.
REQ-016 In each RUN cycle SHALL add the lowest N bits of the latched a and b plus the carry register through one N-bit chunk adder, write the N-bit result into chunk position counter of a working register, update the carry register, shift the latched operands right by N, and increment the counter.
REQ-017 SHALL leave RUN after exactly CHUNKS cycles (counter = CHUNKS-1 on the last one).
REQ-018 Latency: start high in cycle 0 -> busy high cycles 1..CHUNKS -> done high in cycle CHUNKS+1 only.
REQ-019 sum and cout SHALL update only on the RUN->DONE transition and SHALL hold until the next completion or reset; partial results are never visible on sum.
REQ-020 start in RUN or DONE SHALL be ignored, no queuing; start in the IDLE cycle following DONE SHALL be accepted.
REQ-021 Changes on a, b, cin or sub after acceptance SHALL NOT affect the result in progress.
REQ-022 Arithmetic SHALL be modulo 2^W, with cout the true carry out of bit W-1, including carry rippling across every chunk.

Reset
REQ-023 rst high at a clock edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, regardless of state.
REQ-024 Reset during RUN SHALL abandon the operation; no done pulse occurs for it.

Configuration
REQ-025 With WIDE_ADD_SEQ_SUB_EN defined, sub=1 at acceptance SHALL compute sum = a + ~b + 1 (cin ignored), cout=1 meaning no borrow; without the macro, sub SHALL be ignored and the result SHALL always be a + b + cin.

Structure
REQ-026 A shared package wide_add_seq_pkg SHALL hold the FSM state encoding (IDLE=0, RUN=1, DONE=2) and the default N and CHUNKS constants.
REQ-027 The chunk adder SHALL be a separate sub-module csa_slice (N-bit carry-select adder: x, y, cin -> s, cout), instantiated once.

Verification (N=8, CHUNKS=4)
REQ-028 a=0x000000FF, b=0x00000001, cin=0, start in cycle 0 -> busy cycles 1-4, done cycle 5, sum=0x00000100, cout=0.
REQ-029 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1 (full ripple through all chunks).
REQ-030 start held high in cycles 0-6 with operands changing every cycle -> only the cycle-0 operands are used; second accept in cycle 6; sum unchanged between cycles 5 and 10.
REQ-031 rst high in cycle 3 of a run -> busy=0 and sum=0 from cycle 4; done never pulses for that run.
REQ-032 a=0x00000010, b=0x00000020, sub=1 -> with WIDE_ADD_SEQ_SUB_EN: sum=0xFFFFFFF0, cout=0; without it: sum=0x00000030, cout=0.
